// File: rtl/pipeline_hazard_controller_if.sv
// Purpose : bundles the hazard-detection inputs and the stall/flush/forward
//           controls exchanged between the pipeline datapath and the hazard
//           controller.
// Ports   : master = datapath side (drives stage info, receives controls);
//           slave  = hazard controller (receives stage info, drives controls).
interface pipeline_hazard_controller_if #(
  parameter int REG_ADDR_WIDTH = 5
);
  // Stage register numbers
  logic [REG_ADDR_WIDTH-1:0] RsD, RtD, RsE, RtE;
  logic [REG_ADDR_WIDTH-1:0] WriteRegE, WriteRegM, WriteRegW;
  // Stage control bits
  logic RegWriteE, RegWriteM, RegWriteW;
  logic MemtoRegE, MemtoRegM;
  logic BranchD, PCSrcD;
  logic MemReqM, MemReadyM;
  // Controls back to the datapath
  logic StallF, StallD, StallE, StallM;
  logic FlushD, FlushE;
  logic [1:0] ForwardAE, ForwardBE;
  logic ForwardAD, ForwardBD;
  logic MemTimeoutErr;

  modport master (
    output RsD, RtD, RsE, RtE, WriteRegE, WriteRegM, WriteRegW,
    output RegWriteE, RegWriteM, RegWriteW, MemtoRegE, MemtoRegM,
    output BranchD, PCSrcD, MemReqM, MemReadyM,
    input  StallF, StallD, StallE, StallM, FlushD, FlushE,
    input  ForwardAE, ForwardBE, ForwardAD, ForwardBD, MemTimeoutErr
  );

  modport slave (
    input  RsD, RtD, RsE, RtE, WriteRegE, WriteRegM, WriteRegW,
    input  RegWriteE, RegWriteM, RegWriteW, MemtoRegE, MemtoRegM,
    input  BranchD, PCSrcD, MemReqM, MemReadyM,
    output StallF, StallD, StallE, StallM, FlushD, FlushE,
    output ForwardAE, ForwardBE, ForwardAD, ForwardBD, MemTimeoutErr
  );
endinterface

// File: rtl/pipeline_hazard_controller.sv
// Purpose : hazard unit for a 5-stage pipeline: operand forwarding, load-use
//           and branch stalls, and a memory-wait FSM with timeout error.
// Latency : forward/stall/flush outputs are combinational from the current
//           inputs and FSM state; the FSM and counters update on CLK.
// Ports   : CLK, RST (sync, active-high); hz (slave modport) carries all
//           stage info in and stall/flush/forward controls out.
//           Optional macro HAZARD_PERF_CNT_EN adds StallCount/FlushCount.
module pipeline_hazard_controller #(
  parameter int REG_ADDR_WIDTH = 5,
  parameter int MEM_TIMEOUT    = 15,
  parameter int CNT_WIDTH      = 32
) (
  input  logic                        CLK,
  input  logic                        RST,
  pipeline_hazard_controller_if.slave hz
`ifdef HAZARD_PERF_CNT_EN
  ,
  output logic [CNT_WIDTH-1:0]        StallCount,
  output logic [CNT_WIDTH-1:0]        FlushCount
`endif
);

  localparam int CW = $clog2(MEM_TIMEOUT + 1);
  localparam logic [CW-1:0] TIMEOUT_VAL = CW'(MEM_TIMEOUT);

  typedef enum logic [1:0] {
    RUN      = 2'd0,
    MEM_WAIT = 2'd1,
    ERROR    = 2'd2
  } state_e;

  state_e        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;

  logic [REG_ADDR_WIDTH-1:0] rs_d, rt_d, rs_e, rt_e;
  assign rs_d = hz.RsD;
  assign rt_d = hz.RtD;
  assign rs_e = hz.RsE;
  assign rt_e = hz.RtE;

  logic memstall, lwstall, brstall, any_stall;
  logic stall_f, flush_d, flush_e;

  // State register
  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q <= RUN;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      RUN: begin
        if (hz.MemReqM && !hz.MemReadyM) begin
          state_d = MEM_WAIT;
          cnt_d   = CW'(1);
        end
      end
      MEM_WAIT: begin
        if (hz.MemReadyM) begin
          state_d = RUN;
          cnt_d   = '0;
        end else if (cnt_q == TIMEOUT_VAL) begin
          state_d = ERROR;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      ERROR:   state_d = ERROR;  // only RST leaves ERROR
      default: begin
        state_d = RUN;
        cnt_d   = '0;
      end
    endcase
  end

  // Output logic: hazard detection and control generation
  always_comb begin
    // The RUN term lets a same-cycle MemReadyM cost zero stall cycles.
    memstall = ((state_q == RUN) && hz.MemReqM && !hz.MemReadyM) ||
               (state_q == MEM_WAIT) || (state_q == ERROR);
    lwstall  = hz.MemtoRegE && ((rt_e == rs_d) || (rt_e == rt_d));
    brstall  = hz.BranchD &&
               ((hz.RegWriteE && ((hz.WriteRegE == rs_d) || (hz.WriteRegE == rt_d))) ||
                (hz.MemtoRegM && ((hz.WriteRegM == rs_d) || (hz.WriteRegM == rt_d))));
    any_stall = memstall || lwstall || brstall;

    hz.MemTimeoutErr = (state_q == ERROR);

    if (RST) begin
      // Bubble into Execute while the pipeline is being reset.
      hz.StallF    = 1'b0;
      hz.StallD    = 1'b0;
      hz.StallE    = 1'b0;
      hz.StallM    = 1'b0;
      hz.FlushD    = 1'b0;
      hz.FlushE    = 1'b1;
      hz.ForwardAE = 2'b00;
      hz.ForwardBE = 2'b00;
      hz.ForwardAD = 1'b0;
      hz.ForwardBD = 1'b0;
    end else begin
      hz.StallF = any_stall;
      hz.StallD = any_stall;
      hz.StallE = memstall;
      hz.StallM = memstall;
      // Never insert a bubble while downstream stages are frozen.
      hz.FlushE = (lwstall || brstall) && !memstall;
      hz.FlushD = hz.PCSrcD && !any_stall;

      // Memory stage has priority: it holds the younger result.
      if ((rs_e != '0) && hz.RegWriteM && (hz.WriteRegM == rs_e))      hz.ForwardAE = 2'b10;
      else if ((rs_e != '0) && hz.RegWriteW && (hz.WriteRegW == rs_e)) hz.ForwardAE = 2'b01;
      else                                                            hz.ForwardAE = 2'b00;

      if ((rt_e != '0) && hz.RegWriteM && (hz.WriteRegM == rt_e))      hz.ForwardBE = 2'b10;
      else if ((rt_e != '0) && hz.RegWriteW && (hz.WriteRegW == rt_e)) hz.ForwardBE = 2'b01;
      else                                                            hz.ForwardBE = 2'b00;

      hz.ForwardAD = (rs_d != '0) && hz.RegWriteM && (hz.WriteRegM == rs_d);
      hz.ForwardBD = (rt_d != '0) && hz.RegWriteM && (hz.WriteRegM == rt_d);
    end
  end

  assign stall_f = hz.StallF;
  assign flush_d = hz.FlushD;
  assign flush_e = hz.FlushE;

`ifdef HAZARD_PERF_CNT_EN
  logic [CNT_WIDTH-1:0] stall_cnt_q, stall_cnt_d;
  logic [CNT_WIDTH-1:0] flush_cnt_q, flush_cnt_d;

  // Saturating event counters
  always_comb begin
    stall_cnt_d = stall_cnt_q;
    flush_cnt_d = flush_cnt_q;
    if (stall_f && (stall_cnt_q != '1))
      stall_cnt_d = stall_cnt_q + CNT_WIDTH'(1);
    if ((flush_d || flush_e) && (flush_cnt_q != '1))
      flush_cnt_d = flush_cnt_q + CNT_WIDTH'(1);
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      stall_cnt_q <= '0;
      flush_cnt_q <= '0;
    end else begin
      stall_cnt_q <= stall_cnt_d;
      flush_cnt_q <= flush_cnt_d;
    end
  end

  assign StallCount = stall_cnt_q;
  assign FlushCount = flush_cnt_q;
`else
  logic unused_ok;
  assign unused_ok = &{1'b0, stall_f, flush_d, flush_e};
`endif

endmodule

// File: tb/tb_pipeline_hazard_controller.sv
module tb_pipeline_hazard_controller;
  localparam int AW = 5;
  localparam int TO = 15;
  localparam int CWID = 32;

  logic CLK = 1'b0;
  logic RST;
  always #5 CLK = ~CLK;

  pipeline_hazard_controller_if #(.REG_ADDR_WIDTH(AW)) hif();

`ifdef HAZARD_PERF_CNT_EN
  logic [CWID-1:0] stall_count, flush_count;
`endif

  pipeline_hazard_controller #(
    .REG_ADDR_WIDTH(AW), .MEM_TIMEOUT(TO), .CNT_WIDTH(CWID)
  ) dut (
    .CLK(CLK),
    .RST(RST),
    .hz(hif)
`ifdef HAZARD_PERF_CNT_EN
    ,
    .StallCount(stall_count),
    .FlushCount(flush_count)
`endif
  );

  typedef struct packed {
    logic rst;
    logic [AW-1:0] rsd, rtd, rse, rte, wre, wrm, wrw;
    logic rwe, rwm, rww, m2re, m2rm, brd, pcs, req, rdy;
  } stim_t;

  // Expected vector: {StallF,StallD,StallE,StallM,FlushD,FlushE,FAE,FBE,FAD,FBD,Err}
  logic [12:0] exp_q[$];
  int checks = 0;
  int passed = 0;
  int cyc = 0;

  // Reference model state: cycles spent waiting on memory, sticky error
  int m_wait = 0;
  bit m_err = 0;
  int m_stall_cnt = 0;
  int m_flush_cnt = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
    checks++;
    if (act === expv) passed++;
    else $display("FAIL %s: got 0x%0h, want 0x%0h", name, act, expv);
  endtask

  function automatic logic [1:0] fwd_e(input stim_t s, input logic [AW-1:0] src);
    if (src != 0 && s.rwm && s.wrm == src) return 2'b10;
    if (src != 0 && s.rww && s.wrw == src) return 2'b01;
    return 2'b00;
  endfunction

  function automatic logic [12:0] predict(input stim_t s);
    bit mem, lw, br, sf, fe, fd, fad, fbd;
    mem = m_err || (m_wait > 0) || (s.req && !s.rdy);
    lw  = s.m2re && (s.rte == s.rsd || s.rte == s.rtd);
    br  = s.brd && ((s.rwe && (s.wre == s.rsd || s.wre == s.rtd)) ||
                    (s.m2rm && (s.wrm == s.rsd || s.wrm == s.rtd)));
    if (s.rst) return {4'b0000, 1'b0, 1'b1, 4'b0000, 2'b00, m_err};
    sf  = mem || lw || br;
    fe  = (lw || br) && !mem;
    fd  = s.pcs && !sf;
    fad = s.rwm && s.wrm == s.rsd && s.rsd != 0;
    fbd = s.rwm && s.wrm == s.rtd && s.rtd != 0;
    return {sf, sf, mem, mem, fd, fe, fwd_e(s, s.rse), fwd_e(s, s.rte), fad, fbd, m_err};
  endfunction

  // Advance the model across the edge that samples these inputs.
  task automatic advance(input stim_t s, input logic [12:0] e);
    if (s.rst) begin
      m_wait = 0; m_err = 0; m_stall_cnt = 0; m_flush_cnt = 0;
    end else begin
      m_stall_cnt += int'(e[12]);
      m_flush_cnt += int'(e[8] | e[7]);
      if (!m_err) begin
        if (m_wait == 0) begin
          if (s.req && !s.rdy) m_wait = 1;
        end else if (s.rdy) m_wait = 0;
        else if (m_wait == TO) begin m_err = 1; m_wait = 0; end
        else m_wait++;
      end
    end
  endtask

  task automatic apply(input stim_t s);
    RST = s.rst;
    hif.RsD = s.rsd; hif.RtD = s.rtd; hif.RsE = s.rse; hif.RtE = s.rte;
    hif.WriteRegE = s.wre; hif.WriteRegM = s.wrm; hif.WriteRegW = s.wrw;
    hif.RegWriteE = s.rwe; hif.RegWriteM = s.rwm; hif.RegWriteW = s.rww;
    hif.MemtoRegE = s.m2re; hif.MemtoRegM = s.m2rm;
    hif.BranchD = s.brd; hif.PCSrcD = s.pcs;
    hif.MemReqM = s.req; hif.MemReadyM = s.rdy;
  endtask

  task automatic step(input stim_t s);
    logic [12:0] e;
    @(posedge CLK);
    #1;
    apply(s);
    e = predict(s);
    exp_q.push_back(e);
    advance(s, e);
  endtask

  // Monitor: the DUT presents a fresh control vector every cycle.
  always @(negedge CLK) begin : monitor
    logic [12:0] e, a;
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      a = {hif.StallF, hif.StallD, hif.StallE, hif.StallM, hif.FlushD, hif.FlushE,
           hif.ForwardAE, hif.ForwardBE, hif.ForwardAD, hif.ForwardBD, hif.MemTimeoutErr};
      chk($sformatf("sb_cyc%0d", cyc), {19'b0, a}, {19'b0, e});
      cyc++;
    end
  end

  initial begin
    stim_t s;
    int n_stall, n_fe;
    s = '0; s.rst = 1'b1;
    apply(s);

    // Reset: two cycles
    step(s); step(s);
    @(negedge CLK);
    chk("rst_flushE", hif.FlushE, 1);
    chk("rst_stallF", hif.StallF, 0);

    s = '0; step(s);
    @(negedge CLK);
    chk("idle_err", hif.MemTimeoutErr, 0);

    // Load-use stall lasts exactly one cycle
    s = '0; s.m2re = 1; s.rte = 8; s.rsd = 8; step(s);
    @(negedge CLK);
    chk("lw_stallF", hif.StallF, 1);
    chk("lw_stallD", hif.StallD, 1);
    chk("lw_flushE", hif.FlushE, 1);
    s = '0; step(s);
    @(negedge CLK);
    chk("lw_release", hif.StallF, 0);

    // Forwarding priority and r0 exclusion
    s = '0; s.rwm = 1; s.wrm = 5; s.rww = 1; s.wrw = 5; s.rse = 5; step(s);
    @(negedge CLK);
    chk("fwd_mem_prio", hif.ForwardAE, 2'b10);
    s.rse = 0; step(s);
    @(negedge CLK);
    chk("fwd_r0", hif.ForwardAE, 2'b00);

    // Memory wait: 3 not-ready cycles then ready -> 4 stall cycles
    n_stall = 0; n_fe = 0;
    for (int i = 0; i < 4; i++) begin
      s = '0; s.req = 1; s.rdy = (i == 3); step(s);
      @(negedge CLK);
      n_stall += int'(hif.StallM) + int'(hif.StallF & hif.StallD & hif.StallE) - 1;
      n_fe += int'(hif.FlushE);
    end
    chk("mem_stall_cycles", n_stall, 4);
    chk("mem_no_flushE", n_fe, 0);
    s = '0; step(s);
    @(negedge CLK);
    chk("mem_back_run", hif.StallF, 0);

    // Same-cycle ready: no stall
    s = '0; s.req = 1; s.rdy = 1; step(s);
    @(negedge CLK);
    chk("mem_zero_stall", hif.StallM, 0);

    // Timeout: 1 RUN cycle + 15 MEM_WAIT cycles, then ERROR
    for (int i = 0; i < 16; i++) begin
      s = '0; s.req = 1; s.rdy = 0; step(s);
    end
    @(negedge CLK);
    chk("to_last_wait", hif.MemTimeoutErr, 0);
    s = '0; s.rdy = 1; step(s);
    @(negedge CLK);
    chk("to_err_set", hif.MemTimeoutErr, 1);
    chk("to_err_stall", hif.StallF, 1);
    step(s);
    @(negedge CLK);
    chk("to_err_sticky", hif.MemTimeoutErr, 1);
    s = '0; s.rst = 1; step(s);
    s = '0; step(s);
    @(negedge CLK);
    chk("to_err_cleared", hif.MemTimeoutErr, 0);
    chk("to_run_stall", hif.StallF, 0);

    // Taken branch flushes Decode unless a stall is present
    s = '0; s.pcs = 1; step(s);
    @(negedge CLK);
    chk("br_flushD", hif.FlushD, 1);
    s.m2re = 1; s.rte = 3; s.rsd = 3; step(s);
    @(negedge CLK);
    chk("br_flushD_lw", hif.FlushD, 0);

`ifdef HAZARD_PERF_CNT_EN
    s = '0; s.rst = 1; step(s);
    s = '0; s.m2re = 1; s.rte = 8; s.rsd = 8; step(s);
    s = '0; step(s);
    s = '0; s.m2re = 1; s.rte = 4; s.rtd = 4; step(s);
    s = '0; step(s);
    s = '0; s.brd = 1; s.pcs = 1; step(s);
    s = '0; step(s);
    @(negedge CLK);
    chk("perf_stall", stall_count, 2);
    chk("perf_flush", flush_count, 3);
`endif

    // Randomized traffic with hazard-prone small register numbers
    for (int i = 0; i < 400; i++) begin
      s.rst  = ($urandom_range(0, 59) == 0);
      s.rsd  = AW'($urandom_range(0, 3)); s.rtd = AW'($urandom_range(0, 3));
      s.rse  = AW'($urandom_range(0, 3)); s.rte = AW'($urandom_range(0, 3));
      s.wre  = AW'($urandom_range(0, 3)); s.wrm = AW'($urandom_range(0, 3));
      s.wrw  = AW'($urandom_range(0, 3));
      s.rwe  = 1'($urandom_range(0, 1)); s.rwm  = 1'($urandom_range(0, 1));
      s.rww  = 1'($urandom_range(0, 1)); s.m2re = 1'($urandom_range(0, 1));
      s.m2rm = 1'($urandom_range(0, 1)); s.brd  = 1'($urandom_range(0, 1));
      s.pcs  = 1'($urandom_range(0, 1)); s.req  = 1'($urandom_range(0, 1));
      s.rdy  = ($urandom_range(0, 3) != 0);
      step(s);
    end

    // Drain the scoreboard with a bounded wait
    for (int i = 0; i < 5 && exp_q.size() > 0; i++) @(negedge CLK);
    #1;
    chk("sb_drain", exp_q.size(), 0);
`ifdef HAZARD_PERF_CNT_EN
    chk("perf_stall_model", stall_count, m_stall_cnt);
    chk("perf_flush_model", flush_count, m_flush_cnt);
`endif

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end
endmodule

// File: doc/pipeline_hazard_controller.md
PIPELINE_HAZARD_CONTROLLER -- requirements
Module: pipeline_hazard_controller

Interface
REQ-001 The block SHALL have the following parameters:
- REG_ADDR_WIDTH, default 5, register-address width.
- MEM_TIMEOUT, default 15, maximum memory-wait cycles before error.
- CNT_WIDTH, default 32, perf-counter width.

REQ-002 The block SHALL have the following ports:
- CLK  in  1  single clock; all state updates on the rising edge.
- RST  in  1  synchronous, active-high reset.
- RsD, RtD, RsE, RtE  in  REG_ADDR_WIDTH each  source register numbers in Decode and Execute.
- WriteRegE, WriteRegM, WriteRegW  in  REG_ADDR_WIDTH each  destination register per stage.
- RegWriteE, RegWriteM, RegWriteW  in  1 each  write enables per stage.
- MemtoRegE, MemtoRegM  in  1 each  load in Execute or Memory.
- BranchD  in  1  branch in Decode.
- PCSrcD  in  1  branch taken.
- MemReqM  in  1  data-memory access in Memory.
- MemReadyM  in  1  data memory done.
- StallF, StallD, StallE, StallM  out  1 each  hold the stage register.
- FlushD, FlushE  out  1 each  clear the stage register (FlushE drives the Decode-to-Execute CLR).
- ForwardAE, ForwardBE  out  2 each  ALU operand select: 00 = register file, 10 = Memory, 01 = Writeback.
- ForwardAD, ForwardBD  out  1 each  branch comparator forward from Memory.
- MemTimeoutErr  out  1  sticky memory-timeout flag.

Function
REQ-003 ForwardAE SHALL be 10 when RegWriteM and WriteRegM == RsE and RsE != 0; else 01 when RegWriteW and WriteRegW == RsE and RsE != 0; else 00 (same rule for ForwardBE using RtE).
REQ-004 ForwardAD/ForwardBD SHALL be 1 when RegWriteM, WriteRegM == RsD/RtD and that register != 0.
REQ-005 lwstall SHALL be MemtoRegE and (RtE == RsD or RtE == RtD).
REQ-006 brstall SHALL be BranchD and ((RegWriteE and WriteRegE matches RsD or RtD) or (MemtoRegM and WriteRegM matches RsD or RtD)).
REQ-007 The FSM SHALL have states RUN, MEM_WAIT and ERROR; the state and a wait counter (width ceil(log2(MEM_TIMEOUT+1))) SHALL be registered.
REQ-008 In RUN: if MemReqM and not MemReadyM, next state SHALL be MEM_WAIT with counter = 1; else remain in RUN.
REQ-009 In MEM_WAIT: MemReadyM SHALL return to RUN with counter cleared; otherwise, if counter == MEM_TIMEOUT, go to ERROR; else counter increments.
REQ-010 ERROR SHALL be exited only by RST; MemTimeoutErr SHALL be 1 in ERROR.
REQ-011 memstall SHALL be (state == RUN and MemReqM and not MemReadyM) or state == MEM_WAIT or state == ERROR.
REQ-012 StallE and StallM SHALL equal memstall.
REQ-013 StallF and StallD SHALL equal memstall or lwstall or brstall.
REQ-014 FlushE SHALL equal (lwstall or brstall) and not memstall, so a bubble is never inserted while downstream stages are held.
REQ-015 FlushD SHALL equal PCSrcD and not (memstall or lwstall or brstall).
REQ-016 A MemReadyM in the same cycle as MemReqM SHALL cause zero stall cycles.
REQ-017 Forwarding outputs SHALL remain valid during memstall.

Reset
REQ-018 While RST is 1, the block SHALL take state = RUN, counter = 0, MemTimeoutErr = 0 and perf counters = 0 at the next edge.
REQ-019 While RST is 1, the combinational outputs SHALL be forced to: all Stall outputs 0, FlushD 0, FlushE 1, Forward outputs 0.
REQ-020 RST asserted mid-MEM_WAIT or in ERROR SHALL return the block to RUN on the next edge.

Configuration
REQ-021 With HAZARD_PERF_CNT_EN defined, the block SHALL add:
- output StallCount (CNT_WIDTH), incremented on every cycle in which StallF is 1;
- output FlushCount (CNT_WIDTH), incremented on every cycle in which FlushE or FlushD is 1.
Both counters SHALL saturate at all-ones.
REQ-022 Without HAZARD_PERF_CNT_EN, these ports and counters SHALL be absent and behaviour SHALL otherwise be identical.

Verification
REQ-023 The bench SHALL cover the following directed scenarios:
- MemtoRegE = 1, RtE = 8, RsD = 8 -> StallF = StallD = FlushE = 1 for exactly 1 cycle.
- RegWriteM = 1, WriteRegM = 5, RegWriteW = 1, WriteRegW = 5, RsE = 5 -> ForwardAE = 10; with RsE = 0 -> 00.
- MemReqM = 1, MemReadyM held 0 for 3 cycles then 1 -> StallF..StallM = 1 for 4 cycles, FlushE = 0, state back to RUN.
- MemReadyM held 0 with MEM_TIMEOUT = 15 -> ERROR after 15 MEM_WAIT cycles, MemTimeoutErr = 1 until RST, then 0 after RST.
- PCSrcD = 1 with no stall -> FlushD = 1; PCSrcD = 1 during lwstall -> FlushD = 0.
- HAZARD_PERF_CNT_EN defined, 2 load-use stalls plus 1 taken branch -> StallCount = 2, FlushCount = 3.
